// File: rtl/conv_feeder.sv
// ============================================================================
// Module   : conv_feeder
// Purpose  : Streams kernel weights and feature-map words from BRAMs into
//            conv_blk, counts its result strobes and flags layer completion.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module conv_feeder #(
  parameter int KERNEL_SIZE = 3,
  parameter int FM_SIZE     = 252,
  parameter int PADDING     = 0,
  parameter int STRIDE      = 1,
  parameter int MAXPOOL     = 0,
  parameter int GAP_CYCLES  = 2,
  localparam int K2       = KERNEL_SIZE * KERNEL_SIZE,
  localparam int F2       = FM_SIZE * FM_SIZE,
  localparam int WA       = (K2 > 1) ? $clog2(K2) : 1,
  localparam int FA       = (F2 > 1) ? $clog2(F2) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  output logic [WA-1:0] o_read_weight_bram,
  input  logic [17:0]   i_weight,
  output logic [FA-1:0] o_read_fm_bram,
  input  logic [29:0]   i_fm,
  output logic          o_weight_en,
  output logic [17:0]   o_weight_data,
  output logic          o_go,
  output logic [29:0]   o_fm_data,
  input  logic          i_conv_en,
  output logic          o_busy,
  output logic          o_done
);

  localparam int OUT_SIZE = ((FM_SIZE - KERNEL_SIZE + 2 * PADDING) / STRIDE) + 1;
  localparam int N_OUT    = (MAXPOOL != 0) ? (OUT_SIZE / 2) * (OUT_SIZE / 2)
                                           : OUT_SIZE * OUT_SIZE;
  localparam int RW       = (N_OUT > 0) ? $clog2(N_OUT + 1) : 1;
  localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [WA-1:0] c_w_last   = WA'(K2 - 1);
  localparam logic [FA-1:0] c_fm_last  = FA'(F2 - 1);
  localparam logic [GW-1:0] c_gap_last = GW'(GAP_CYCLES - 1);
  localparam logic [RW-1:0] c_n_out    = RW'(N_OUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_GAP    = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [WA-1:0] r_w_cnt;
  logic [GW-1:0] r_gap_cnt;
  logic [FA-1:0] r_fm_cnt;
  logic [RW-1:0] r_res_cnt;
  logic          r_weight_en;
  logic          w_res_hit;
  logic [RW-1:0] w_res_next;

  // Result strobes only count while conv_blk is being fed; the count saturates.
  assign w_res_hit  = ((r_state == S_STREAM) || (r_state == S_DRAIN)) &&
                      i_conv_en && (r_res_cnt != c_n_out);
  assign w_res_next = r_res_cnt + RW'(w_res_hit);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (i_start) w_next = S_LOAD_W;
      S_LOAD_W: if (r_w_cnt == c_w_last) w_next = S_GAP;
      S_GAP:    if (r_gap_cnt == c_gap_last) w_next = S_STREAM;
      S_STREAM: if (r_fm_cnt == c_fm_last)
                  w_next = (w_res_next == c_n_out) ? S_DONE : S_DRAIN;
      S_DRAIN:  if (w_res_next == c_n_out) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_w_cnt     <= '0;
      r_gap_cnt   <= '0;
      r_fm_cnt    <= '0;
      r_res_cnt   <= '0;
      r_weight_en <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_weight_en <= (r_state == S_LOAD_W);
      r_w_cnt     <= (r_state == S_LOAD_W) ? r_w_cnt + WA'(1) : '0;
      r_gap_cnt   <= (r_state == S_GAP) ? r_gap_cnt + GW'(1) : '0;
      if (r_state == S_STREAM) begin
        if (r_fm_cnt != c_fm_last) r_fm_cnt <= r_fm_cnt + FA'(1);
      end else if (r_state != S_DRAIN) begin
        r_fm_cnt <= '0;
      end
      r_res_cnt   <= (r_state == S_DONE) ? '0 : w_res_next;
    end
  end

  // BRAM data arrives one cycle after its address, so the weight strobe and
  // the FM address both run one step ahead of/behind the raw counters.
  always_comb begin
    o_read_weight_bram = (r_state == S_LOAD_W) ? r_w_cnt : '0;
    o_weight_en        = r_weight_en;
    o_weight_data      = r_weight_en ? i_weight : 18'd0;
    o_go               = (r_state == S_STREAM) || (r_state == S_DRAIN);
    o_fm_data          = (r_state == S_STREAM) ? i_fm : 30'd0;
    o_read_fm_bram     = '0;
    if (r_state == S_STREAM)
      o_read_fm_bram = (r_fm_cnt == c_fm_last) ? c_fm_last : r_fm_cnt + FA'(1);
    else if (r_state == S_DRAIN)
      o_read_fm_bram = c_fm_last;
    o_busy             = (r_state != S_IDLE);
    o_done             = (r_state == S_DONE);
  end

endmodule

`default_nettype wire

// File: tb/tb_conv_feeder.sv
// Scoreboard bench for conv_feeder: two instances (MAXPOOL=0/GAP=2 and
// MAXPOOL=1/GAP=1) driven with randomized BRAM contents and result strobes.
`default_nettype none

module tb_conv_feeder;
  localparam int K2 = 9;
  localparam int F2 = 25;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_a, start_b, cen_a, cen_b;
  logic [3:0]  wa_a, wa_b;
  logic [4:0]  fa_a, fa_b;
  logic [17:0] wq_a, wq_b, wd_a, wd_b;
  logic [29:0] fq_a, fq_b, fd_a, fd_b;
  logic        wen_a, wen_b, go_a, go_b, busy_a, busy_b, done_a, done_b;

  logic [17:0] wmem [16];
  logic [29:0] fmem [32];

  always @(posedge clk) begin
    wq_a <= wmem[wa_a];
    wq_b <= wmem[wa_b];
    fq_a <= fmem[fa_a];
    fq_b <= fmem[fa_b];
  end

  conv_feeder #(.KERNEL_SIZE(3), .FM_SIZE(5), .PADDING(0), .STRIDE(1),
                .MAXPOOL(0), .GAP_CYCLES(2)) u_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_a),
    .o_read_weight_bram(wa_a), .i_weight(wq_a),
    .o_read_fm_bram(fa_a), .i_fm(fq_a),
    .o_weight_en(wen_a), .o_weight_data(wd_a),
    .o_go(go_a), .o_fm_data(fd_a), .i_conv_en(cen_a),
    .o_busy(busy_a), .o_done(done_a));

  conv_feeder #(.KERNEL_SIZE(3), .FM_SIZE(5), .PADDING(0), .STRIDE(1),
                .MAXPOOL(1), .GAP_CYCLES(1)) u_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b),
    .o_read_weight_bram(wa_b), .i_weight(wq_b),
    .o_read_fm_bram(fa_b), .i_fm(fq_b),
    .o_weight_en(wen_b), .o_weight_data(wd_b),
    .o_go(go_b), .o_fm_data(fd_b), .i_conv_en(cen_b),
    .o_busy(busy_b), .o_done(done_b));

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        wen;
    logic [17:0] wd;
    logic        go;
    logic [29:0] fd;
    logic [3:0]  wa;
    logic        chk_fa;
    logic [4:0]  fa;
  } obs_t;

  obs_t obs_a, obs_b;
  assign obs_a = {busy_a, done_a, wen_a, wd_a, go_a, fd_a, wa_a, 1'b1, fa_a};
  assign obs_b = {busy_b, done_b, wen_b, wd_b, go_b, fd_b, wa_b, 1'b1, fa_b};

  obs_t qa[$];
  obs_t qb[$];
  int   pulses[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic obs_t idle_obs();
    obs_t e = '0;
    e.chk_fa = 1'b1;
    return e;
  endfunction

  task automatic cmp(input string nm, input obs_t e, input obs_t a);
    obs_t m;
    m = a;
    m.chk_fa = e.chk_fa;
    if (!e.chk_fa) m.fa = e.fa;
    n_cmp++;
    if (m !== e) begin
      n_bad++;
      $display("FAIL %s t=%0t got busy=%b done=%b wen=%b wd=%h go=%b fd=%h wa=%0d fa=%0d | want busy=%b done=%b wen=%b wd=%h go=%b fd=%h wa=%0d fa=%0d(chk=%b)",
               nm, $time, a.busy, a.done, a.wen, a.wd, a.go, a.fd, a.wa, a.fa,
               e.busy, e.done, e.wen, e.wd, e.go, e.fd, e.wa, e.fa, e.chk_fa);
    end
  endtask

  // Monitor: one expected entry per cycle while a pass is traced, idle otherwise.
  always @(negedge clk) begin
    obs_t ea, eb;
    ea = (qa.size() > 0) ? qa.pop_front() : idle_obs();
    eb = (qb.size() > 0) ? qb.pop_front() : idle_obs();
    cmp("inst_a", ea, obs_a);
    cmp("inst_b", eb, obs_b);
  end

  // Reference: the whole pass as a per-cycle trace, cycle 0 = start-pulse cycle.
  task automatic push_trace(input bit inst, input int abort_c, output int d);
    int gap, nout, s, cnt, pn, endc;
    obs_t e;
    gap  = inst ? 1 : 2;
    nout = inst ? 1 : 9;
    s    = K2 + gap + 1;
    cnt  = 0;
    pn   = -1;
    foreach (pulses[i])
      if (pulses[i] >= s && cnt < nout) begin
        cnt++;
        if (cnt == nout) pn = pulses[i];
      end
    d    = (pn + 1 > s + F2) ? pn + 1 : s + F2;
    endc = (abort_c >= 0) ? abort_c - 1 : d;
    for (int c = 0; c <= endc; c++) begin
      e        = '0;
      e.busy   = (c >= 1) && (c <= d);
      e.done   = (c == d);
      e.wen    = (c >= 2) && (c <= K2 + 1);
      e.wd     = e.wen ? wmem[c-2] : 18'd0;
      e.wa     = (c >= 1 && c <= K2) ? 4'(c - 1) : 4'd0;
      e.go     = (c >= s) && (c < d);
      e.fd     = (e.go && (c - s) < F2) ? fmem[c-s] : 30'd0;
      e.chk_fa = (c == 0) || (c == s - 1) || e.go;
      e.fa     = e.go ? 5'(((c - s + 1) < F2 - 1) ? (c - s + 1) : F2 - 1) : 5'd0;
      if (inst) qb.push_back(e);
      else      qa.push_back(e);
    end
  endtask

  task automatic run_pass(input bit inst, input int abort_c, input int xs1, input int xs2);
    int d, last, lastp;
    logic st, ce;
    @(posedge clk);
    #1;
    push_trace(inst, abort_c, d);
    lastp = (pulses.size() > 0) ? pulses[pulses.size()-1] : 0;
    last  = (abort_c >= 0) ? abort_c : ((lastp > d) ? lastp : d);
    for (int c = 0; c <= last; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      st = (c == 0) || (c == xs1) || (c == xs2);
      ce = 1'b0;
      foreach (pulses[i]) if (pulses[i] == c) ce = 1'b1;
      if (inst) begin start_b = st; cen_b = ce; end
      else      begin start_a = st; cen_a = ce; end
      rst = (c == abort_c);
    end
    @(posedge clk);
    #1;
    start_a = 0; start_b = 0; cen_a = 0; cen_b = 0; rst = 0;
    repeat (2) @(posedge clk);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 16; i++) wmem[i] = 18'($urandom);
    for (int i = 0; i < 32; i++) fmem[i] = 30'($urandom);
  endtask

  task automatic gen_pulses(input bit inst);
    int s, n, p;
    s = K2 + (inst ? 1 : 2) + 1;
    n = (inst ? 1 : 9) + 3 + int'($urandom_range(0, 2));
    p = int'($urandom_range(s - 3, s + F2 + 3));
    pulses.delete();
    for (int i = 0; i < n; i++) begin
      pulses.push_back(p);
      p += int'($urandom_range(1, 3));
    end
  endtask

  initial begin
    rst = 1; start_a = 0; start_b = 0; cen_a = 0; cen_b = 0;
    for (int i = 0; i < 16; i++) wmem[i] = 18'(i + 1);
    for (int i = 0; i < 32; i++) fmem[i] = 30'(i);
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Basic pass: weights 1..9, FM 0..24, nine strobes in DRAIN.
    pulses = '{40, 42, 44, 46, 48, 50, 52, 54, 56};
    run_pass(0, -1, -1, -1);

    // MAXPOOL: one strobe mid-stream (plus one in LOAD_W that must not count).
    pulses = '{5, 16};
    run_pass(1, -1, -1, -1);

    // Reset at STREAM sample 10, then a fresh pass from address 0.
    fill_rand();
    pulses.delete();
    run_pass(0, 22, -1, -1);
    pulses = '{37, 38, 39, 40, 41, 42, 43, 44, 45};
    run_pass(0, -1, -1, -1);

    // Stray start pulses in LOAD_W and STREAM.
    run_pass(0, -1, 3, 16);

    // Twelve strobes: extras land in DONE/IDLE; next pass counts from zero.
    pulses = '{38, 39, 40, 41, 42, 43, 44, 45, 46, 47, 48, 49};
    run_pass(0, -1, -1, -1);
    pulses = '{37, 39, 41, 43, 45, 47, 49, 51, 53};
    run_pass(0, -1, -1, -1);

    // GAP=1 with negative FM samples; strobe on the last stream cycle, then in DRAIN.
    fmem[0] = 30'h3FFFFFFF;
    fmem[7] = 30'h20000000;
    pulses = '{35};
    run_pass(1, -1, -1, -1);
    pulses = '{38};
    run_pass(1, -1, -1, -1);

    for (int k = 0; k < 10; k++) begin
      bit inst;
      fill_rand();
      inst = 1'($urandom);
      gen_pulses(inst);
      run_pass(inst, -1, -1, -1);
    end

    repeat (3) @(posedge clk);
    n_cmp++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_bad++;
      $display("FAIL trace_drained got qa=%0d qb=%0d want 0 0", qa.size(), qb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
